// File: rtl/ifm_stream_reader.sv
// Streams a packed feature map out of BRAM one element per cycle. Up to two
// words are buffered (cur/nxt) so a continuously ready consumer never starves.
module ifm_stream_reader #(
    parameter int WI                 = 8,
    parameter int BRAM_DATA_WIDTH    = 32,
    parameter int BRAM_DATA_DEPTH    = 16384,
    parameter int BRAM_ADDRESS_WIDTH = 14,
    parameter int MAX_FEATURE_SIZE   = 18
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ap_start,
    input  logic [8:0]                    ifm_w,
    input  logic [8:0]                    in_ch,
    input  logic [BRAM_ADDRESS_WIDTH-1:0] base_addr,
    output logic [BRAM_ADDRESS_WIDTH-1:0] bram_addr,
    output logic                          bram_en,
    input  logic [BRAM_DATA_WIDTH-1:0]    bram_rdata,
    output logic [WI-1:0]                 ifm_data,
    output logic                          ifm_vld,
    input  logic                          ifm_rdy,
    output logic                          ifm_last,
    output logic                          ap_done,
    output logic                          ap_idle
);

    localparam int LANES   = BRAM_DATA_WIDTH / WI;
    localparam int LANE_W  = $clog2(LANES);
    localparam int WORDS_W = MAX_FEATURE_SIZE + 1 - LANE_W;

    // Addresses wrap modulo 2^BRAM_ADDRESS_WIDTH, so the BRAM must span that range exactly.
    if (BRAM_DATA_DEPTH != (1 << BRAM_ADDRESS_WIDTH)) begin : g_depth_check
        $error("BRAM_DATA_DEPTH must equal 2**BRAM_ADDRESS_WIDTH");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                          r_state;
    state_t                          w_state_nxt;

    logic [BRAM_ADDRESS_WIDTH-1:0]   r_base;
    logic [MAX_FEATURE_SIZE-1:0]     r_total;
    logic [WORDS_W-1:0]              r_num_words;
    logic [WORDS_W-1:0]              r_words_issued;
    logic [MAX_FEATURE_SIZE-1:0]     r_elem_idx;
    logic [LANE_W-1:0]               r_byte_idx;
    logic [BRAM_DATA_WIDTH-1:0]      r_cur;
    logic [BRAM_DATA_WIDTH-1:0]      r_nxt;
    logic                            r_cur_vld;
    logic                            r_nxt_vld;
    logic                            r_inflight;

    logic                            w_start;
    logic [MAX_FEATURE_SIZE-1:0]     w_total;
    logic [MAX_FEATURE_SIZE:0]       w_total_rnd;
    logic [WORDS_W-1:0]              w_num_words;
    logic [1:0]                      w_occ;
    logic                            w_issue;
    logic [BRAM_ADDRESS_WIDTH-1:0]   w_addr;
    logic                            w_xfer;
    logic                            w_last_elem;
    logic                            w_cur_done;
    logic                            w_cur_free;
    logic [WI-1:0]                   w_lanes [LANES];

    // Element count is defined modulo 2^MAX_FEATURE_SIZE, so the product is formed at that width.
    assign w_total     = MAX_FEATURE_SIZE'(ifm_w) * MAX_FEATURE_SIZE'(ifm_w)
                       * MAX_FEATURE_SIZE'(in_ch);
    assign w_total_rnd = {1'b0, w_total} + (MAX_FEATURE_SIZE + 1)'(LANES - 1);
    assign w_num_words = WORDS_W'(w_total_rnd >> LANE_W);

    assign w_start     = (r_state == S_IDLE) && ap_start;
    assign w_occ       = {1'b0, r_cur_vld} + {1'b0, r_nxt_vld} + {1'b0, r_inflight};
    assign w_issue     = (r_state == S_RUN) && (r_words_issued < r_num_words) && (w_occ < 2'd2);
    assign w_addr      = r_base + r_words_issued[BRAM_ADDRESS_WIDTH-1:0];

    assign w_xfer      = r_cur_vld && ifm_rdy;
    assign w_last_elem = (r_elem_idx == r_total - MAX_FEATURE_SIZE'(1));
    // The final word is abandoned after its last valid lane, leaving upper lanes unseen.
    assign w_cur_done  = w_xfer && ((r_byte_idx == LANE_W'(LANES - 1)) || w_last_elem);
    assign w_cur_free  = !r_cur_vld || w_cur_done;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign w_lanes[k] = r_cur[k*WI +: WI];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Empty maps pass through RUN for one cycle; no read is issued there.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (ap_start) w_state_nxt = S_RUN;
            S_RUN:   if ((r_total == '0) || (w_xfer && w_last_elem)) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ap_idle = 1'b0;
        ap_done = 1'b0;
        unique case (r_state)
            S_IDLE:  ap_idle = 1'b1;
            S_DONE:  ap_done = 1'b1;
            default: ;
        endcase
    end

    assign bram_en   = w_issue;
    assign bram_addr = w_issue ? w_addr : '0;
    assign ifm_vld   = r_cur_vld;
    assign ifm_data  = w_lanes[r_byte_idx];
    assign ifm_last  = r_cur_vld && w_last_elem;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_base         <= '0;
            r_total        <= '0;
            r_num_words    <= '0;
            r_words_issued <= '0;
            r_elem_idx     <= '0;
            r_byte_idx     <= '0;
            r_cur          <= '0;
            r_nxt          <= '0;
            r_cur_vld      <= 1'b0;
            r_nxt_vld      <= 1'b0;
            r_inflight     <= 1'b0;
        end else if (w_start) begin
            r_base         <= base_addr;
            r_total        <= w_total;
            r_num_words    <= w_num_words;
            r_words_issued <= '0;
            r_elem_idx     <= '0;
            r_byte_idx     <= '0;
            r_cur_vld      <= 1'b0;
            r_nxt_vld      <= 1'b0;
            r_inflight     <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_words_issued <= r_words_issued + WORDS_W'(1);
            end
            if (w_xfer) begin
                r_elem_idx <= r_elem_idx + MAX_FEATURE_SIZE'(1);
            end
            if (w_cur_done) begin
                r_byte_idx <= '0;
            end else if (w_xfer) begin
                r_byte_idx <= r_byte_idx + LANE_W'(1);
            end
            // A return coinciding with cur being vacated lands behind whatever nxt holds.
            if (w_cur_free) begin
                if (r_nxt_vld) begin
                    r_cur     <= r_nxt;
                    r_cur_vld <= 1'b1;
                    r_nxt_vld <= r_inflight;
                    if (r_inflight) begin
                        r_nxt <= bram_rdata;
                    end
                end else if (r_inflight) begin
                    r_cur     <= bram_rdata;
                    r_cur_vld <= 1'b1;
                end else begin
                    r_cur_vld <= 1'b0;
                end
            end else if (r_inflight) begin
                r_nxt     <= bram_rdata;
                r_nxt_vld <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ifm_stream_reader.sv
// Directed bench for ifm_stream_reader with a one-cycle-latency BRAM model.
module tb_ifm_stream_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        ap_start;
    logic [8:0]  ifm_w;
    logic [8:0]  in_ch;
    logic [13:0] base_addr;
    logic [13:0] bram_addr;
    logic        bram_en;
    logic [31:0] bram_rdata = '0;
    logic [7:0]  ifm_data;
    logic        ifm_vld;
    logic        ifm_rdy;
    logic        ifm_last;
    logic        ap_done;
    logic        ap_idle;

    logic [31:0] mem [0:16383];

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc;
    int          rdy_mode;
    int          exp_total;
    int          done_cyc;
    int          n_words_done;
    int          max_occ;
    int          stall_viol;
    int          en_outside;
    logic        prev_stall;
    logic [7:0]  prev_data;
    logic        prev_last;
    logic [7:0]  out_q [$];
    logic        last_q [$];
    int          out_cyc [$];
    int          rd_addr [$];
    int          rd_cyc [$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bram_en) bram_rdata <= mem[bram_addr];
    end

    ifm_stream_reader dut (
        .clk        (clk),
        .rst        (rst),
        .ap_start   (ap_start),
        .ifm_w      (ifm_w),
        .in_ch      (in_ch),
        .base_addr  (base_addr),
        .bram_addr  (bram_addr),
        .bram_en    (bram_en),
        .bram_rdata (bram_rdata),
        .ifm_data   (ifm_data),
        .ifm_vld    (ifm_vld),
        .ifm_rdy    (ifm_rdy),
        .ifm_last   (ifm_last),
        .ap_done    (ap_done),
        .ap_idle    (ap_idle)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] get_out(input int i);
        if (i < out_q.size()) return 32'(out_q[i]);
        return 'x;
    endfunction

    function automatic logic [31:0] get_last(input int i);
        if (i < last_q.size()) return 32'(last_q[i]);
        return 'x;
    endfunction

    function automatic logic [31:0] get_cyc(input int i);
        if (i < out_cyc.size()) return out_cyc[i];
        return 'x;
    endfunction

    function automatic logic [31:0] get_rd(input int i);
        if (i < rd_addr.size()) return rd_addr[i];
        return 'x;
    endfunction

    function automatic int count_last();
        int n = 0;
        foreach (last_q[i]) if (last_q[i]) n++;
        return n;
    endfunction

    task automatic clear_log();
        out_q.delete();
        last_q.delete();
        out_cyc.delete();
        rd_addr.delete();
        rd_cyc.delete();
        done_cyc     = -1;
        n_words_done = 0;
        max_occ      = 0;
        stall_viol   = 0;
        en_outside   = 0;
        prev_stall   = 1'b0;
        prev_data    = '0;
        prev_last    = 1'b0;
    endtask

    // Advance one clock and log everything visible in the new cycle.
    task automatic step();
        int occ;
        @(posedge clk);
        #1;
        cyc++;
        ap_start = 1'b0;
        ifm_rdy  = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        if (prev_stall && (!ifm_vld || ifm_data !== prev_data || ifm_last !== prev_last))
            stall_viol++;
        occ = rd_addr.size() + int'(bram_en) - n_words_done;
        if (occ > max_occ) max_occ = occ;
        if (bram_en) begin
            if (ap_idle || ap_done) en_outside++;
            rd_addr.push_back(int'(bram_addr));
            rd_cyc.push_back(cyc);
        end
        if (ifm_vld && ifm_rdy) begin
            if ((out_q.size() % 4 == 3) || (out_q.size() == exp_total - 1)) n_words_done++;
            out_q.push_back(ifm_data);
            last_q.push_back(ifm_last);
            out_cyc.push_back(cyc);
        end
        if (ap_done && done_cyc < 0) done_cyc = cyc;
        prev_stall = ifm_vld && !ifm_rdy;
        prev_data  = ifm_data;
        prev_last  = ifm_last;
    endtask

    task automatic start_run(input int w, input int ch, input int base, input int total);
        clear_log();
        exp_total = total;
        ifm_w     = 9'(w);
        in_ch     = 9'(ch);
        base_addr = 14'(base);
        ap_start  = 1'b1;
        cyc       = 0;
    endtask

    task automatic run_to_done(input string tag, input int budget);
        int n = 0;
        while (!ap_done && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_done_seen"}, 32'(ap_done), 32'd1);
        step();
        chk({tag, "_done_one_cycle"}, 32'(ap_done), 32'd0);
        chk({tag, "_idle_after"}, 32'(ap_idle), 32'd1);
        chk({tag, "_en_outside_run"}, en_outside, 0);
    endtask

    task automatic fill_ramp64();
        for (int i = 0; i < 16; i++)
            mem[i] = {8'(4*i + 3 + 64), 8'(4*i + 2 + 64), 8'(4*i + 1 + 64), 8'(4*i + 64)};
    endtask

    task automatic check_ramp64(input string tag);
        int bad = 0;
        int bad_addr = 0;
        chk({tag, "_count"}, out_q.size(), 64);
        for (int i = 0; i < 64; i++)
            if (get_out(i) !== 32'(8'(i + 64))) bad++;
        chk({tag, "_order_errs"}, bad, 0);
        chk({tag, "_last_flag"}, get_last(63), 32'd1);
        chk({tag, "_last_count"}, count_last(), 1);
        chk({tag, "_reads"}, rd_addr.size(), 16);
        for (int i = 0; i < 16; i++)
            if (get_rd(i) !== 32'(i)) bad_addr++;
        chk({tag, "_addr_errs"}, bad_addr, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int gaps;
        rst       = 1'b1;
        ap_start  = 1'b0;
        ifm_w     = '0;
        in_ch     = '0;
        base_addr = '0;
        ifm_rdy   = 1'b1;
        rdy_mode  = 0;
        cyc       = 0;
        exp_total = 0;
        clear_log();
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        chk("rst_idle", 32'(ap_idle), 32'd1);
        chk("rst_done", 32'(ap_done), 32'd0);
        chk("rst_en", 32'(bram_en), 32'd0);
        chk("rst_addr", 32'(bram_addr), 32'd0);
        chk("rst_vld", 32'(ifm_vld), 32'd0);
        chk("rst_data", 32'(ifm_data), 32'd0);
        chk("rst_last", 32'(ifm_last), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single word, four elements
        mem[0] = 32'h44332211;
        start_run(2, 1, 0, 4);
        run_to_done("t1", 50);
        chk("t1_count", out_q.size(), 4);
        chk("t1_e0", get_out(0), 32'h11);
        chk("t1_e1", get_out(1), 32'h22);
        chk("t1_e2", get_out(2), 32'h33);
        chk("t1_e3", get_out(3), 32'h44);
        chk("t1_first_vld_cyc", get_cyc(0), 32'd3);
        chk("t1_last_xfer_cyc", get_cyc(3), 32'd6);
        chk("t1_last_flag", get_last(3), 32'd1);
        chk("t1_last_count", count_last(), 1);
        chk("t1_done_cyc", done_cyc, 7);
        chk("t1_reads", rd_addr.size(), 1);
        chk("t1_first_en_cyc", (rd_cyc.size() > 0) ? rd_cyc[0] : -1, 1);
        chk("t1_addr0", get_rd(0), 32'd0);

        // Nine elements: final word only partially emitted
        mem[0] = 32'h04030201;
        mem[1] = 32'h08070605;
        mem[2] = 32'hDDCCBB09;
        start_run(3, 1, 0, 9);
        run_to_done("t2", 80);
        chk("t2_count", out_q.size(), 9);
        for (int i = 0; i < 9; i++)
            chk($sformatf("t2_e%0d", i), get_out(i), 32'(i + 1));
        chk("t2_last_flag", get_last(8), 32'd1);
        chk("t2_last_count", count_last(), 1);
        chk("t2_reads", rd_addr.size(), 3);
        chk("t2_addr2", get_rd(2), 32'd2);

        // 64 elements, consumer always ready
        fill_ramp64();
        start_run(4, 4, 0, 64);
        run_to_done("t3", 200);
        check_ramp64("t3");
        gaps = 0;
        for (int i = 0; i < 64; i++)
            if (get_cyc(i) !== 32'(3 + i)) gaps++;
        chk("t3_vld_gaps", gaps, 0);
        chk("t3_done_cyc", done_cyc, 67);

        // 64 elements, random backpressure
        rdy_mode = 1;
        start_run(4, 4, 0, 64);
        run_to_done("t4", 2000);
        check_ramp64("t4");
        chk("t4_stall_stable", stall_viol, 0);
        chk("t4_occ_le2", 32'(max_occ <= 2), 32'd1);
        rdy_mode = 0;

        // Address wrap at the top of the BRAM
        mem[16383] = 32'hA3A2A1A0;
        mem[0]     = 32'hA7A6A5A4;
        start_run(2, 2, 16383, 8);
        run_to_done("t5", 80);
        chk("t5_count", out_q.size(), 8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("t5_e%0d", i), get_out(i), 32'(8'hA0 + i));
        chk("t5_reads", rd_addr.size(), 2);
        chk("t5_addr0", get_rd(0), 32'd16383);
        chk("t5_addr1", get_rd(1), 32'd0);

        // Empty map
        start_run(5, 0, 0, 0);
        run_to_done("t6a", 20);
        chk("t6a_done_cyc", done_cyc, 2);
        chk("t6a_reads", rd_addr.size(), 0);
        chk("t6a_count", out_q.size(), 0);

        // Reset during element 5, then a clean rerun
        fill_ramp64();
        start_run(4, 4, 0, 64);
        n = 0;
        while (out_q.size() < 5 && n < 50) begin
            step();
            n++;
        end
        step();
        chk("t6b_pre_rst_vld", 32'(ifm_vld), 32'd1);
        chk("t6b_pre_rst_data", 32'(ifm_data), 32'h45);
        rst = 1'b1;
        step();
        chk("t6b_rst_idle", 32'(ap_idle), 32'd1);
        chk("t6b_rst_done", 32'(ap_done), 32'd0);
        chk("t6b_rst_en", 32'(bram_en), 32'd0);
        chk("t6b_rst_addr", 32'(bram_addr), 32'd0);
        chk("t6b_rst_vld", 32'(ifm_vld), 32'd0);
        chk("t6b_rst_data", 32'(ifm_data), 32'd0);
        chk("t6b_rst_last", 32'(ifm_last), 32'd0);
        rst = 1'b0;
        start_run(4, 4, 0, 64);
        run_to_done("t6b", 200);
        check_ramp64("t6b");
        chk("t6b_done_cyc", done_cyc, 67);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
